// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 ASCII buffer slice.
// Holds the Set-2 control codes, modifier tag bit positions, the ASCII control
// characters produced by the lookup table, the FIFO entry type and the helper
// that folds Shift/Ctrl into a lowercase letter.
package ps2_pkg;

    // Set-2 control scancodes (consumed by the upstream decoder)
    localparam logic [7:0] LSHIFT = 8'h12;
    localparam logic [7:0] LCTRL  = 8'h14;
    localparam logic [7:0] LALT   = 8'h11;
    localparam logic [7:0] BREAK  = 8'hF0;

    // Bit positions inside the 3-bit modifier tag
    localparam int TAG_SHIFT = 2;
    localparam int TAG_CTRL  = 1;
    localparam int TAG_ALT   = 0;

    // ASCII control characters
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_TAB   = 8'h09;
    localparam logic [7:0] ASCII_ESC   = 8'h1B;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef struct packed {
        logic [2:0] tag;
        logic [7:0] ascii;
    } fifoEntry_t;

    // Ctrl beats Shift; Alt never changes the character; only letters are affected.
    function automatic logic [7:0] applyModifiers(input logic [7:0] lower, input logic [2:0] tag);
        logic [7:0] result;
        result = lower;
        if (lower >= 8'h61 && lower <= 8'h7A) begin
            if (tag[TAG_CTRL]) begin
                result = lower & 8'h1F;
            end else if (tag[TAG_SHIFT]) begin
                result = lower - 8'h20;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/ps2_set2_lut.sv
// Combinational Set-2 scancode to lowercase ASCII table.
// Ports:
//   iScan    in  8  Set-2 make code
//   oMapped  out 1  scancode has an ASCII translation
//   oAscii   out 8  unshifted ASCII (0 when unmapped)
module ps2_set2_lut
    import ps2_pkg::*;
(
    input  logic [7:0] iScan,
    output logic       oMapped,
    output logic [7:0] oAscii
);

    always_comb begin
        oMapped = 1'b1;
        oAscii  = 8'h00;
        case (iScan)
            8'h1C: oAscii = "a";
            8'h32: oAscii = "b";
            8'h21: oAscii = "c";
            8'h23: oAscii = "d";
            8'h24: oAscii = "e";
            8'h2B: oAscii = "f";
            8'h34: oAscii = "g";
            8'h33: oAscii = "h";
            8'h43: oAscii = "i";
            8'h3B: oAscii = "j";
            8'h42: oAscii = "k";
            8'h4B: oAscii = "l";
            8'h3A: oAscii = "m";
            8'h31: oAscii = "n";
            8'h44: oAscii = "o";
            8'h4D: oAscii = "p";
            8'h15: oAscii = "q";
            8'h2D: oAscii = "r";
            8'h1B: oAscii = "s";
            8'h2C: oAscii = "t";
            8'h3C: oAscii = "u";
            8'h2A: oAscii = "v";
            8'h1D: oAscii = "w";
            8'h22: oAscii = "x";
            8'h35: oAscii = "y";
            8'h1A: oAscii = "z";
            8'h45: oAscii = "0";
            8'h16: oAscii = "1";
            8'h1E: oAscii = "2";
            8'h26: oAscii = "3";
            8'h25: oAscii = "4";
            8'h2E: oAscii = "5";
            8'h36: oAscii = "6";
            8'h3D: oAscii = "7";
            8'h3E: oAscii = "8";
            8'h46: oAscii = "9";
            8'h29: oAscii = ASCII_SPACE;
            8'h5A: oAscii = ASCII_CR;
            8'h66: oAscii = ASCII_BS;
            8'h0D: oAscii = ASCII_TAB;
            8'h76: oAscii = ASCII_ESC;
            default: oMapped = 1'b0;
        endcase
    end

endmodule

// File: rtl/ps2_ascii_buffer.sv
// PS/2 scancode to ASCII translator with a first-word-fall-through FIFO.
// Three-stage pipeline: capture, table lookup + modifiers, FIFO write.
// Ports:
//   CLOCK, RESET         clock and asynchronous active-high reset
//   iTrig, iData, iTag   one-cycle make-code strobe, scancode, {Shift,Ctrl,Alt}
//   iAck                 pop the head entry (ignored when empty)
//   iClear               synchronous clear of oOverflow and oDrop
//   oValid, oAscii, oTag head entry (FWFT), valid when FIFO not empty
//   oCount               entries held, 0..DEPTH
//   oOverflow            sticky: mapped key lost to a full FIFO
//   oDrop                saturating count of unmapped scancodes
module ps2_ascii_buffer
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          CLOCK,
    input  logic          RESET,
    input  logic          iTrig,
    input  logic [7:0]    iData,
    input  logic [2:0]    iTag,
    input  logic          iAck,
    input  logic          iClear,
    output logic          oValid,
    output logic [7:0]    oAscii,
    output logic [2:0]    oTag,
    output logic [AW:0]   oCount,
    output logic          oOverflow,
    output logic [7:0]    oDrop
);

    logic          s1Vld;
    logic [7:0]    s1Data;
    logic [2:0]    s1Tag;
    logic          s2Vld;
    fifoEntry_t    s2Entry;

    fifoEntry_t    mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [AW:0]   count;
    logic          overflow;
    logic [7:0]    dropCnt;

    logic          lutMapped;
    logic [7:0]    lutAscii;
    logic          fifoFull;
    logic          pop;
    logic          push;
    logic          ovEvent;
    logic          dropEvent;

    ps2_set2_lut uLut (
        .iScan   (s1Data),
        .oMapped (lutMapped),
        .oAscii  (lutAscii)
    );

    assign fifoFull  = (count == (AW+1)'(DEPTH));
    assign pop       = iAck && (count != '0);
    // A pop on the same edge frees the slot the write needs.
    assign push      = s2Vld && (!fifoFull || pop);
    assign ovEvent   = s2Vld && fifoFull && !pop;
    assign dropEvent = s1Vld && !lutMapped;

    // Pipeline stages 1 and 2
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            s1Vld   <= 1'b0;
            s1Data  <= 8'h00;
            s1Tag   <= 3'b000;
            s2Vld   <= 1'b0;
            s2Entry <= '0;
        end else begin
            s1Vld <= iTrig;
            if (iTrig) begin
                s1Data <= iData;
                s1Tag  <= iTag;
            end
            s2Vld <= s1Vld && lutMapped;
            if (s1Vld) begin
                s2Entry.tag   <= s1Tag;
                s2Entry.ascii <= applyModifiers(lutAscii, s1Tag);
            end
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge CLOCK) begin
        if (push) begin
            mem[wrPtr] <= s2Entry;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

    // Status: a same-edge event wins over iClear.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            overflow <= 1'b0;
            dropCnt  <= 8'h00;
        end else begin
            if (ovEvent) begin
                overflow <= 1'b1;
            end else if (iClear) begin
                overflow <= 1'b0;
            end
            if (dropEvent) begin
                if (iClear) begin
                    dropCnt <= 8'h01;
                end else if (dropCnt != 8'hFF) begin
                    dropCnt <= dropCnt + 8'h01;
                end
            end else if (iClear) begin
                dropCnt <= 8'h00;
            end
        end
    end

    assign oValid    = (count != '0);
    assign oAscii    = oValid ? mem[rdPtr].ascii : 8'h00;
    assign oTag      = oValid ? mem[rdPtr].tag : 3'b000;
    assign oCount    = count;
    assign oOverflow = overflow;
    assign oDrop     = dropCnt;

endmodule

// File: tb/tb_ps2_ascii_buffer.sv
// Self-checking bench for ps2_ascii_buffer: a queue-based reference model that
// tracks each key by the edge it arrived on, compared against the DUT every
// cycle, plus directed scenarios with literal expectations.
module tb_ps2_ascii_buffer;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b1;
    logic       iTrig = 1'b0;
    logic [7:0] iData = 8'h00;
    logic [2:0] iTag = 3'b000;
    logic       iAck = 1'b0;
    logic       iClear = 1'b0;
    logic       oValid;
    logic [7:0] oAscii;
    logic [2:0] oTag;
    logic [3:0] oCount;
    logic       oOverflow;
    logic [7:0] oDrop;

    int total = 0;
    int bad = 0;

    ps2_ascii_buffer #(.DEPTH(8), .AW(3)) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .iTrig     (iTrig),
        .iData     (iData),
        .iTag      (iTag),
        .iAck      (iAck),
        .iClear    (iClear),
        .oValid    (oValid),
        .oAscii    (oAscii),
        .oTag      (oTag),
        .oCount    (oCount),
        .oOverflow (oOverflow),
        .oDrop     (oDrop)
    );

    always #5 CLOCK = ~CLOCK;

    // Translation tables: letters in alphabet order, digits in numeric order.
    logic [7:0] letterCodes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                     8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                     8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                     8'h35, 8'h1A};
    logic [7:0] digitCodes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                    8'h3E, 8'h46};
    logic [7:0] specCodes [5] = '{8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76};
    logic [7:0] specAscii [5] = '{8'h20, 8'h0D, 8'h08, 8'h09, 8'h1B};

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void modelMap(input logic [7:0] code, input logic [2:0] tag,
                                     output logic ok, output logic [7:0] asc);
        ok = 1'b0;
        asc = 8'h00;
        for (int i = 0; i < 26; i++) begin
            if (letterCodes[i] == code) begin
                ok = 1'b1;
                if (tag[1]) asc = 8'(i + 1);           // Ctrl-A = 1 ... Ctrl-Z = 26
                else if (tag[2]) asc = 8'(8'h41 + i);  // 'A'..
                else asc = 8'(8'h61 + i);              // 'a'..
            end
        end
        for (int i = 0; i < 10; i++) begin
            if (digitCodes[i] == code) begin
                ok = 1'b1;
                asc = 8'(8'h30 + i);
            end
        end
        for (int i = 0; i < 5; i++) begin
            if (specCodes[i] == code) begin
                ok = 1'b1;
                asc = specAscii[i];
            end
        end
    endfunction

    // Reference model: a key triggered on edge e is looked up on edge e+1
    // (drop counted there) and written on edge e+2.
    typedef struct {
        int         e;
        logic [7:0] d;
        logic [2:0] t;
    } key_t;

    key_t        pend[$];
    logic [10:0] mq[$];
    logic        mOv = 1'b0;
    int          mDrop = 0;
    int          edgeNo = 0;

    always @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            mq.delete();
            pend.delete();
            mOv = 1'b0;
            mDrop = 0;
        end else begin : modelStep
            logic        ok;
            logic [7:0]  a;
            logic [10:0] wEnt;
            bit          wr;
            bit          dropEv;
            bit          ovEv;
            bit          popNow;
            int          sz;
            edgeNo++;
            wr = 0;
            dropEv = 0;
            ovEv = 0;
            wEnt = '0;
            foreach (pend[i]) begin
                modelMap(pend[i].d, pend[i].t, ok, a);
                if (pend[i].e == edgeNo - 2 && ok) begin
                    wr = 1;
                    wEnt = {pend[i].t, a};
                end
                if (pend[i].e == edgeNo - 1 && !ok) dropEv = 1;
            end
            while (pend.size() > 0 && pend[0].e <= edgeNo - 2) void'(pend.pop_front());
            sz = mq.size();
            popNow = iAck && sz > 0;
            if (popNow) void'(mq.pop_front());
            if (wr) begin
                if (sz < 8 || popNow) mq.push_back(wEnt);
                else ovEv = 1;
            end
            if (iTrig) pend.push_back('{edgeNo, iData, iTag});
            if (ovEv) mOv = 1'b1;
            else if (iClear) mOv = 1'b0;
            if (dropEv) mDrop = iClear ? 1 : (mDrop < 255 ? mDrop + 1 : 255);
            else if (iClear) mDrop = 0;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge CLOCK) begin
        if (!RESET) begin
            chk("cyc_valid", int'(oValid), int'(mq.size() > 0));
            chk("cyc_count", int'(oCount), mq.size());
            chk("cyc_overflow", int'(oOverflow), int'(mOv));
            chk("cyc_drop", int'(oDrop), mDrop);
            if (mq.size() > 0) begin
                chk("cyc_ascii", int'(oAscii), int'(mq[0][7:0]));
                chk("cyc_tag", int'(oTag), int'(mq[0][10:8]));
            end
        end
    end

    task automatic step(input logic tr, input logic [7:0] d, input logic [2:0] t,
                        input logic ak, input logic cl);
        @(negedge CLOCK);
        #1;
        iTrig = tr;
        iData = d;
        iTag = t;
        iAck = ak;
        iClear = cl;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00, 3'b000, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        @(negedge CLOCK);
        #1;
        iTrig = 1'b0;
        iAck = 1'b0;
        iClear = 1'b0;
        RESET = 1'b1;
        #2;
        RESET = 1'b0;
    endtask

    // Check the head, then pop it on the next edge.
    task automatic popExp(input string name, input logic [7:0] asc, input logic [2:0] tag);
        chk({name, "_ascii"}, int'(oAscii), int'(asc));
        chk({name, "_tag"}, int'(oTag), int'(tag));
        step(1'b0, 8'h00, 3'b000, 1'b1, 1'b0);
        @(posedge CLOCK);
        #1;
    endtask

    initial begin
        #12;
        chk("rst_valid", int'(oValid), 0);
        chk("rst_count", int'(oCount), 0);
        chk("rst_ascii", int'(oAscii), 0);
        chk("rst_ovf_drop", int'({oOverflow, oDrop}), 0);
        RESET = 1'b0;

        // 1: basic latency and pop
        step(1'b1, 8'h1C, 3'b000, 1'b0, 1'b0);
        idle(2);
        chk("t1_valid_T2", int'(oValid), 0);
        idle(1);
        chk("t1_valid_T3", int'(oValid), 1);
        chk("t1_ascii", int'(oAscii), 8'h61);
        chk("t1_tag", int'(oTag), 0);
        chk("t1_count", int'(oCount), 1);
        step(1'b0, 8'h00, 3'b000, 1'b1, 1'b0);
        idle(1);
        chk("t1_pop_valid", int'(oValid), 0);
        chk("t1_pop_count", int'(oCount), 0);

        // 2: modifiers, back-to-back
        step(1'b1, 8'h1C, 3'b100, 1'b0, 1'b0);
        step(1'b1, 8'h1C, 3'b110, 1'b0, 1'b0);
        step(1'b1, 8'h16, 3'b100, 1'b0, 1'b0);
        step(1'b1, 8'h5A, 3'b000, 1'b0, 1'b0);
        idle(3);
        chk("t2_count", int'(oCount), 4);
        popExp("t2_shiftA", 8'h41, 3'b100);
        popExp("t2_ctrlA", 8'h01, 3'b110);
        popExp("t2_shift1", 8'h31, 3'b100);
        popExp("t2_cr", 8'h0D, 3'b000);

        // 3: unmapped scancode and clear
        step(1'b1, 8'h05, 3'b000, 1'b0, 1'b0);
        idle(3);
        chk("t3_valid", int'(oValid), 0);
        chk("t3_drop", int'(oDrop), 1);
        step(1'b0, 8'h00, 3'b000, 1'b0, 1'b1);
        idle(1);
        chk("t3_clear", int'(oDrop), 0);

        // 4: overflow with nine keys
        doReset();
        for (int i = 0; i < 9; i++) step(1'b1, letterCodes[i], 3'b000, 1'b0, 1'b0);
        idle(3);
        chk("t4_count", int'(oCount), 8);
        chk("t4_overflow", int'(oOverflow), 1);
        for (int i = 0; i < 8; i++) popExp("t4_drain", 8'(8'h61 + i), 3'b000);
        chk("t4_empty", int'(oValid), 0);

        // 5: full FIFO, pop lands on the write edge
        doReset();
        for (int i = 0; i < 8; i++) step(1'b1, letterCodes[i], 3'b000, 1'b0, 1'b0);
        idle(3);
        chk("t5_full", int'(oCount), 8);
        step(1'b1, 8'h1A, 3'b000, 1'b0, 1'b0);
        idle(1);
        step(1'b0, 8'h00, 3'b000, 1'b1, 1'b0);
        idle(1);
        chk("t5_count", int'(oCount), 8);
        chk("t5_overflow", int'(oOverflow), 0);
        for (int i = 1; i < 8; i++) popExp("t5_drain", 8'(8'h61 + i), 3'b000);
        popExp("t5_tail", 8'h7A, 3'b000);
        chk("t5_empty", int'(oValid), 0);

        // 6: async reset mid-pipeline
        doReset();
        step(1'b1, 8'h1C, 3'b000, 1'b0, 1'b0);
        step(1'b1, 8'h05, 3'b000, 1'b0, 1'b0);
        idle(3);
        step(1'b1, 8'h32, 3'b000, 1'b0, 1'b0);
        @(negedge CLOCK);
        #1;
        iTrig = 1'b0;
        #1;
        RESET = 1'b1;
        #1;
        chk("t6_valid", int'(oValid), 0);
        chk("t6_count", int'(oCount), 0);
        chk("t6_drop", int'(oDrop), 0);
        #1;
        RESET = 1'b0;
        idle(5);
        chk("t6_after_valid", int'(oValid), 0);
        chk("t6_after_count", int'(oCount), 0);

        // Drop counter saturation
        doReset();
        repeat (260) step(1'b1, 8'h05, 3'b000, 1'b0, 1'b0);
        idle(3);
        chk("sat_drop", int'(oDrop), 255);

        // Randomized traffic against the model
        doReset();
        repeat (1500) begin
            logic [7:0] code;
            int sel;
            sel = $urandom_range(0, 4);
            if (sel == 0) code = 8'($urandom_range(0, 255));
            else if (sel == 1) code = digitCodes[$urandom_range(0, 9)];
            else if (sel == 2) code = specCodes[$urandom_range(0, 4)];
            else code = letterCodes[$urandom_range(0, 25)];
            step(1'($urandom_range(0, 9) < 6), code, 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 39) == 0));
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
